// File: rtl/alu_exec_stage.sv
// Execute stage for Type A instructions: single-cycle ADD/SUB/AND/OR and iterative
// unsigned MUL/DIV. MUL/DIV send the high word or remainder to the dedicated R15 port.
module alu_exec_stage #(
    parameter int         DATA_W   = 16,
    parameter logic [3:0] TYPE_A   = 4'hF,
    parameter logic [3:0] R15_ADDR = 4'hF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        opcode,
    input  logic [3:0]        funct,
    input  logic [3:0]        rd,
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    output logic [DATA_W-1:0] Writedata,
    output logic [3:0]        WriteAddr,
    output logic              RegWrite,
    output logic [DATA_W-1:0] R15data,
    output logic              R15Write,
    output logic              overflow,
    output logic              div_by_zero
);

    localparam logic [3:0] F_ADD = 4'b0000;
    localparam logic [3:0] F_SUB = 4'b0001;
    localparam logic [3:0] F_MUL = 4'b0100;
    localparam logic [3:0] F_DIV = 4'b0101;
    localparam logic [3:0] F_AND = 4'b1000;
    localparam logic [3:0] F_OR  = 4'b1001;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [2*DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]     opb_q, opb_d;
    logic [3:0]            rd_q, rd_d;
    logic [DATA_W-1:0]     writedata_q, writedata_d;
    logic [3:0]            writeaddr_q, writeaddr_d;
    logic                  regwrite_q, regwrite_d;
    logic [DATA_W-1:0]     r15data_q, r15data_d;
    logic                  r15write_q, r15write_d;
    logic                  overflow_q, overflow_d;
    logic                  dbz_q, dbz_d;

    logic                  accept;
    logic [DATA_W-1:0]     add_res, sub_res;
    logic [DATA_W:0]       mul_sum;
    logic [2*DATA_W-1:0]   mul_next;
    logic [DATA_W:0]       div_shift;
    logic                  div_ge;
    logic [DATA_W-1:0]     div_diff, div_rem;
    logic [2*DATA_W-1:0]   div_next;

    assign Writedata   = writedata_q;
    assign WriteAddr   = writeaddr_q;
    assign RegWrite    = regwrite_q;
    assign R15data     = r15data_q;
    assign R15Write    = r15write_q;
    assign overflow    = overflow_q;
    assign div_by_zero = dbz_q;

    always_comb begin
        in_ready  = (state_q == S_IDLE) || (state_q == S_DONE);
        accept    = in_valid && in_ready;
        add_res   = op1 + op2;
        sub_res   = op1 - op2;

        // acc holds {high, low}: product being built for MUL, {remainder, dividend/quotient} for DIV
        mul_sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_next  = {mul_sum, acc_q[DATA_W-1:1]};
        div_shift = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
        div_ge    = div_shift >= {1'b0, opb_q};
        div_diff  = div_shift[DATA_W-1:0] - opb_q;
        div_rem   = div_ge ? div_diff : div_shift[DATA_W-1:0];
        div_next  = {div_rem, acc_q[DATA_W-2:0], div_ge};

        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        opb_d       = opb_q;
        rd_d        = rd_q;
        writedata_d = writedata_q;
        writeaddr_d = writeaddr_q;
        regwrite_d  = 1'b0;
        r15data_d   = r15data_q;
        r15write_d  = 1'b0;
        overflow_d  = overflow_q;
        dbz_d       = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept && (opcode == TYPE_A)) begin
                    case (funct)
                        F_ADD: begin
                            writedata_d = add_res;
                            writeaddr_d = rd;
                            regwrite_d  = 1'b1;
                            overflow_d  = (op1[DATA_W-1] == op2[DATA_W-1]) &&
                                          (add_res[DATA_W-1] != op1[DATA_W-1]);
                        end
                        F_SUB: begin
                            writedata_d = sub_res;
                            writeaddr_d = rd;
                            regwrite_d  = 1'b1;
                            overflow_d  = (op1[DATA_W-1] != op2[DATA_W-1]) &&
                                          (sub_res[DATA_W-1] != op1[DATA_W-1]);
                        end
                        F_AND: begin
                            writedata_d = op1 & op2;
                            writeaddr_d = rd;
                            regwrite_d  = 1'b1;
                        end
                        F_OR: begin
                            writedata_d = op1 | op2;
                            writeaddr_d = rd;
                            regwrite_d  = 1'b1;
                        end
                        F_MUL: begin
                            acc_d   = {{DATA_W{1'b0}}, op1};
                            opb_d   = op2;
                            rd_d    = rd;
                            cnt_d   = 4'd0;
                            state_d = S_MUL;
                        end
                        F_DIV: begin
                            if (op2 == '0) begin
                                r15data_d  = op1;
                                r15write_d = 1'b1;
                                dbz_d      = 1'b1;
                                if (rd != R15_ADDR) begin
                                    writedata_d = '1;
                                    writeaddr_d = rd;
                                    regwrite_d  = 1'b1;
                                end
                            end else begin
                                acc_d   = {{DATA_W{1'b0}}, op1};
                                opb_d   = op2;
                                rd_d    = rd;
                                cnt_d   = 4'd0;
                                state_d = S_DIV;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d    = S_DONE;
                    r15data_d  = mul_next[2*DATA_W-1:DATA_W];
                    r15write_d = 1'b1;
                    if (rd_q != R15_ADDR) begin
                        writedata_d = mul_next[DATA_W-1:0];
                        writeaddr_d = rd_q;
                        regwrite_d  = 1'b1;
                    end
                end
            end
            S_DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d    = S_DONE;
                    r15data_d  = div_next[2*DATA_W-1:DATA_W];
                    r15write_d = 1'b1;
                    if (rd_q != R15_ADDR) begin
                        writedata_d = div_next[DATA_W-1:0];
                        writeaddr_d = rd_q;
                        regwrite_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            acc_q       <= '0;
            opb_q       <= '0;
            rd_q        <= 4'd0;
            writedata_q <= '0;
            writeaddr_q <= 4'd0;
            regwrite_q  <= 1'b0;
            r15data_q   <= '0;
            r15write_q  <= 1'b0;
            overflow_q  <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            opb_q       <= opb_d;
            rd_q        <= rd_d;
            writedata_q <= writedata_d;
            writeaddr_q <= writeaddr_d;
            regwrite_q  <= regwrite_d;
            r15data_q   <= r15data_d;
            r15write_q  <= r15write_d;
            overflow_q  <= overflow_d;
            dbz_q       <= dbz_d;
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: expected write-backs are queued when an
// instruction is issued and popped when the stage raises RegWrite or R15Write.
module tb_alu_exec_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  opcode, funct, rd;
    logic [15:0] op1, op2;
    logic [15:0] Writedata, R15data;
    logic [3:0]  WriteAddr;
    logic        RegWrite, R15Write, overflow, div_by_zero;

    alu_exec_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct(funct), .rd(rd), .op1(op1), .op2(op2),
        .Writedata(Writedata), .WriteAddr(WriteAddr), .RegWrite(RegWrite),
        .R15data(R15data), .R15Write(R15Write), .overflow(overflow),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] wd;
        logic [3:0]  wa;
        logic        rw;
        logic [15:0] r15;
        logic        r15w;
        logic        dbz;
        logic        ovf;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [15:0] m_wd = '0, m_r15 = '0;
    logic [3:0]  m_wa = '0;
    logic        m_ovf = 1'b0;

    // Reference model: predicts the write-back of one instruction and queues it
    task automatic issue(input logic [3:0] opc, input logic [3:0] fn, input logic [3:0] rdi,
                         input logic [15:0] a, input logic [15:0] b);
        exp_t        e;
        logic [31:0] p;
        logic [15:0] r;
        bit          push;
        push = 1; e.lat = 1; e.rw = 1; e.r15w = 0; e.dbz = 0;
        if (opc != 4'hF) push = 0;
        else begin
            case (fn)
                4'h0: begin r = a + b; m_ovf = (a[15] == b[15]) && (r[15] != a[15]); m_wd = r; m_wa = rdi; end
                4'h1: begin r = a - b; m_ovf = (a[15] != b[15]) && (r[15] != a[15]); m_wd = r; m_wa = rdi; end
                4'h8: begin m_wd = a & b; m_wa = rdi; end
                4'h9: begin m_wd = a | b; m_wa = rdi; end
                4'h4: begin
                    p = {16'h0, a} * {16'h0, b};
                    e.lat = 17; e.r15w = 1; m_r15 = p[31:16];
                    if (rdi != 4'hF) begin m_wd = p[15:0]; m_wa = rdi; end else e.rw = 0;
                end
                4'h5: begin
                    e.r15w = 1;
                    if (b == 16'h0) begin
                        e.dbz = 1; m_r15 = a; r = 16'hFFFF;
                    end else begin
                        e.lat = 17; m_r15 = a % b; r = a / b;
                    end
                    if (rdi != 4'hF) begin m_wd = r; m_wa = rdi; end else e.rw = 0;
                end
                default: push = 0;
            endcase
        end
        e.wd = m_wd; e.wa = m_wa; e.r15 = m_r15; e.ovf = m_ovf;
        if (push) sb.push_back(e);
        opcode = opc; funct = fn; rd = rdi; op1 = a; op2 = b; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Waits (bounded) for a write strobe; k=41 means it never came
    task automatic wait_strobe(output int k, output int busy);
        busy = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (in_ready !== 1'b1) busy++;
            if (RegWrite === 1'b1 || R15Write === 1'b1) begin
                in_valid = 1'b0;
                k = i;
                return;
            end
        end
        k = 41;
    endtask

    task automatic test_reset;
        reset = 1'b0; in_valid = 1'b0; opcode = '0; funct = '0; rd = '0; op1 = '0; op2 = '0;
        #12;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready: got %b want 1", in_ready); end
        n_cmp++;
        if ({Writedata, WriteAddr, R15data} !== 36'h0) begin
            n_fail++; $display("[TB] FAIL reset_data: got wd=%h wa=%h r15=%h want zeros", Writedata, WriteAddr, R15data);
        end
        n_cmp++;
        if ({RegWrite, R15Write, overflow, div_by_zero} !== 4'b0) begin
            n_fail++; $display("[TB] FAIL reset_flags: got %b want 0000", {RegWrite, R15Write, overflow, div_by_zero});
        end
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_alu;
        logic [3:0]  fns[7] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h8, 4'h9, 4'h0};
        logic [3:0]  rds[7] = '{4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd2, 4'd1};
        logic [15:0] as[7]  = '{16'h0F00, 16'h6666, 16'h0002, 16'h8000, 16'hF0F0, 16'hF0F0, 16'hFFFF};
        logic [15:0] bs[7]  = '{16'h0050, 16'h6666, 16'h0002, 16'h0001, 16'h3C3C, 16'h0F0F, 16'h0001};
        exp_t e;
        int   k, busy;
        for (int i = 0; i < 7; i++) begin
            issue(4'hF, fns[i], rds[i], as[i], bs[i]);
            wait_strobe(k, busy);
            if (sb.size() == 0) begin n_cmp++; n_fail++; $display("[TB] FAIL alu_queue: strobe with empty scoreboard"); end
            else begin
                e = sb.pop_front();
                n_cmp++; if (k !== e.lat) begin n_fail++; $display("[TB] FAIL alu_latency[%0d]: got %0d want %0d", i, k, e.lat); end
                n_cmp++; if ({Writedata, WriteAddr} !== {e.wd, e.wa}) begin
                    n_fail++; $display("[TB] FAIL alu_data[%0d]: got %h@%0d want %h@%0d", i, Writedata, WriteAddr, e.wd, e.wa); end
                n_cmp++; if ({RegWrite, R15Write, div_by_zero} !== {e.rw, e.r15w, e.dbz}) begin
                    n_fail++; $display("[TB] FAIL alu_strobes[%0d]: got %b want %b", i, {RegWrite, R15Write, div_by_zero}, {e.rw, e.r15w, e.dbz}); end
                n_cmp++; if (overflow !== e.ovf) begin n_fail++; $display("[TB] FAIL alu_overflow[%0d]: got %b want %b", i, overflow, e.ovf); end
            end
            @(negedge clk);
            n_cmp++; if ({RegWrite, R15Write} !== 2'b00) begin n_fail++; $display("[TB] FAIL alu_pulse[%0d]: got %b want 00", i, {RegWrite, R15Write}); end
        end
    endtask

    task automatic test_noop;
        logic [3:0] opcs[3] = '{4'h3, 4'hF, 4'hF};
        logic [3:0] fns[3]  = '{4'h0, 4'h2, 4'hF};
        int seen;
        for (int i = 0; i < 3; i++) begin
            issue(opcs[i], fns[i], 4'd3, 16'h1111, 16'h2222);
            seen = 0;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                if (RegWrite !== 1'b0 || R15Write !== 1'b0 || in_ready !== 1'b1) seen++;
            end
            n_cmp++; if (seen !== 0) begin n_fail++; $display("[TB] FAIL noop_quiet[%0d]: got %0d bad cycles want 0", i, seen); end
            n_cmp++; if ({Writedata, overflow} !== {m_wd, m_ovf}) begin
                n_fail++; $display("[TB] FAIL noop_hold[%0d]: got %h/%b want %h/%b", i, Writedata, overflow, m_wd, m_ovf); end
        end
    endtask

    task automatic test_muldiv;
        logic [3:0]  fns[4] = '{4'h4, 4'h5, 4'h4, 4'h5};
        logic [3:0]  rds[4] = '{4'd9, 4'd10, 4'd15, 4'd15};
        logic [15:0] as[4]  = '{16'h0F00, 16'hFF0F, 16'h1234, 16'hFFFF};
        logic [15:0] bs[4]  = '{16'h0050, 16'h0040, 16'h5678, 16'h0007};
        logic [3:0]  f, r;
        logic [15:0] a, b;
        exp_t e;
        int   k, busy;
        for (int i = 0; i < 8; i++) begin
            if (i < 4) begin f = fns[i]; r = rds[i]; a = as[i]; b = bs[i]; end
            else begin
                f = (i % 2) ? 4'h5 : 4'h4;
                r = 4'($urandom_range(0, 14));
                a = 16'($urandom);
                b = 16'($urandom_range(1, 16'hFFFF));
            end
            issue(4'hF, f, r, a, b);
            // Scribble on the inputs while busy: must be ignored and must not disturb the op
            in_valid = 1'b1; funct = 4'h0; rd = 4'd1; op1 = 16'hFFFF; op2 = 16'h0001;
            wait_strobe(k, busy);
            if (sb.size() == 0) begin n_cmp++; n_fail++; $display("[TB] FAIL md_queue: strobe with empty scoreboard"); end
            else begin
                e = sb.pop_front();
                n_cmp++; if (k !== e.lat) begin n_fail++; $display("[TB] FAIL md_latency[%0d]: got %0d want %0d", i, k, e.lat); end
                n_cmp++; if (busy !== 16) begin n_fail++; $display("[TB] FAIL md_busy[%0d]: got %0d want 16", i, busy); end
                n_cmp++; if ({Writedata, WriteAddr, R15data} !== {e.wd, e.wa, e.r15}) begin
                    n_fail++; $display("[TB] FAIL md_data[%0d]: got %h@%0d r15=%h want %h@%0d r15=%h", i, Writedata, WriteAddr, R15data, e.wd, e.wa, e.r15); end
                n_cmp++; if ({RegWrite, R15Write, div_by_zero, overflow} !== {e.rw, e.r15w, e.dbz, e.ovf}) begin
                    n_fail++; $display("[TB] FAIL md_flags[%0d]: got %b want %b", i, {RegWrite, R15Write, div_by_zero, overflow}, {e.rw, e.r15w, e.dbz, e.ovf}); end
            end
            @(negedge clk);
            n_cmp++; if ({RegWrite, R15Write} !== 2'b00) begin n_fail++; $display("[TB] FAIL md_pulse[%0d]: got %b want 00", i, {RegWrite, R15Write}); end
        end
    endtask

    task automatic test_div_zero;
        exp_t e;
        int   k, busy;
        issue(4'hF, 4'h5, 4'd3, 16'h00FF, 16'h0000);
        wait_strobe(k, busy);
        if (sb.size() == 0) begin n_cmp++; n_fail++; $display("[TB] FAIL dz_queue: strobe with empty scoreboard"); end
        else begin
            e = sb.pop_front();
            n_cmp++; if ({k, busy} !== {e.lat, 32'd0}) begin n_fail++; $display("[TB] FAIL dz_timing: got lat %0d busy %0d want %0d/0", k, busy, e.lat); end
            n_cmp++; if ({Writedata, WriteAddr, R15data} !== {e.wd, e.wa, e.r15}) begin
                n_fail++; $display("[TB] FAIL dz_data: got %h@%0d r15=%h want %h@%0d r15=%h", Writedata, WriteAddr, R15data, e.wd, e.wa, e.r15); end
            n_cmp++; if ({RegWrite, R15Write, div_by_zero} !== {e.rw, e.r15w, e.dbz}) begin
                n_fail++; $display("[TB] FAIL dz_strobes: got %b want %b", {RegWrite, R15Write, div_by_zero}, {e.rw, e.r15w, e.dbz}); end
        end
        @(negedge clk);
        n_cmp++; if ({div_by_zero, in_ready} !== 2'b01) begin n_fail++; $display("[TB] FAIL dz_pulse: got %b want 01", {div_by_zero, in_ready}); end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int   k, busy;
        issue(4'hF, 4'h4, 4'd11, 16'h00FF, 16'h0101);
        wait_strobe(k, busy);
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_ready: got %b want 1", in_ready); end
        if (sb.size() == 0) begin n_cmp++; n_fail++; $display("[TB] FAIL b2b_queue: strobe with empty scoreboard"); end
        else begin
            e = sb.pop_front();
            n_cmp++; if ({k, Writedata, R15data} !== {e.lat, e.wd, e.r15}) begin
                n_fail++; $display("[TB] FAIL b2b_mul: got lat %0d %h/%h want %0d %h/%h", k, Writedata, R15data, e.lat, e.wd, e.r15); end
        end
        issue(4'hF, 4'h0, 4'd12, 16'h7FFF, 16'h0001);
        wait_strobe(k, busy);
        if (sb.size() == 0) begin n_cmp++; n_fail++; $display("[TB] FAIL b2b_queue2: strobe with empty scoreboard"); end
        else begin
            e = sb.pop_front();
            n_cmp++; if ({k, Writedata, WriteAddr, RegWrite, overflow} !== {e.lat, e.wd, e.wa, e.rw, e.ovf}) begin
                n_fail++; $display("[TB] FAIL b2b_add: got lat %0d %h@%0d rw=%b ov=%b want %0d %h@%0d rw=%b ov=%b",
                                   k, Writedata, WriteAddr, RegWrite, overflow, e.lat, e.wd, e.wa, e.rw, e.ovf); end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort;
        int seen;
        issue(4'hF, 4'h4, 4'd9, 16'h1234, 16'h5678);
        repeat (7) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        n_cmp++; if ({Writedata, WriteAddr, R15data, RegWrite, R15Write, overflow, div_by_zero} !== 40'h0) begin
            n_fail++; $display("[TB] FAIL abort_outputs: got wd=%h wa=%h r15=%h flags=%b want zeros", Writedata, WriteAddr, R15data,
                               {RegWrite, R15Write, overflow, div_by_zero}); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL abort_ready: got %b want 1", in_ready); end
        @(negedge clk);
        reset = 1'b1;
        sb.delete();
        m_wd = '0; m_wa = '0; m_r15 = '0; m_ovf = 1'b0;
        seen = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (RegWrite !== 1'b0 || R15Write !== 1'b0 || in_ready !== 1'b1) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_fail++; $display("[TB] FAIL abort_quiet: got %0d bad cycles want 0", seen); end
    endtask

    initial begin
        test_reset;
        test_alu;
        test_noop;
        test_muldiv;
        test_div_zero;
        test_back_to_back;
        test_reset_abort;
        n_cmp++;
        if (sb.size() !== 0) begin n_fail++; $display("[TB] FAIL leftover: %0d entries want 0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
